// File: rtl/spi_master_shifter.sv
// Bit-level SPI master engine: SCLK/MOSI/SS generation and MISO capture, all four CPOL/CPHA modes.
// Optional internal loopback path is built when SPI_LOOPBACK_EN is defined.
module spi_master_shifter #(
  parameter int D_WIDTH = 8,
  parameter int SLAVES  = 1,
  parameter int ADDR_W  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               cont,
  input  logic [7:0]         clk_div,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [D_WIDTH-1:0] tx_data,
  input  logic               miso,
`ifdef SPI_LOOPBACK_EN
  input  logic               loopback,
`endif
  output logic               sclk,
  output logic               mosi,
  output logic [SLAVES-1:0]  ss_n,
  output logic               busy,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               done
);

  localparam int EDGES = 2 * D_WIDTH;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

  state_t state, state_nxt;

  logic               cpol_q;
  logic               cpha_q;
  logic               cont_q;
  logic [7:0]         div_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         cnt;
  logic [EW-1:0]      edge_cnt;
  logic [D_WIDTH-1:0] tx_sh;
  logic [D_WIDTH-1:0] rx_sh;
  logic               half_wrap;
  logic               word_end;
  logic               restart;
  logic               odd_edge;
  logic               sample_bit;
  logic               ss_allow;

  assign half_wrap = (cnt == div_q);
  assign word_end  = (state == XFER) && half_wrap && (edge_cnt == EW'(EDGES));
  assign restart   = word_end && cont_q && enable;
  // edge_cnt holds the number of edges already made, so the upcoming edge is odd when it is even
  assign odd_edge  = ~edge_cnt[0];
  assign busy      = (state != IDLE);

`ifdef SPI_LOOPBACK_EN
  logic lb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lb_q <= 1'b0;
    end else if (state == IDLE && enable) begin
      lb_q <= loopback;
    end
  end

  assign sample_bit = lb_q ? mosi : miso;
  assign ss_allow   = ~lb_q;
`else
  assign sample_bit = miso;
  assign ss_allow   = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = XFER;
      XFER:    if (word_end && !restart) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range addresses simply decode to no select while the transfer still runs
  always_comb begin
    ss_n = '1;
    if (state != IDLE && ss_allow) begin
      for (int i = 0; i < SLAVES; i++) begin
        if (addr_q == ADDR_W'(i)) ss_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      cont_q   <= 1'b0;
      div_q    <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (enable) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            cont_q   <= cont;
            div_q    <= clk_div;
            addr_q   <= addr;
            cnt      <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            if (!cpha) begin
              mosi  <= tx_data[D_WIDTH-1];
              tx_sh <= {tx_data[D_WIDTH-2:0], 1'b0};
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        XFER: begin
          if (word_end) begin
            rx_data  <= rx_sh;
            done     <= 1'b1;
            cnt      <= '0;
            edge_cnt <= '0;
            if (restart) begin
              rx_sh <= '0;
              if (!cpha_q) begin
                mosi  <= tx_data[D_WIDTH-1];
                tx_sh <= {tx_data[D_WIDTH-2:0], 1'b0};
              end else begin
                tx_sh <= tx_data;
              end
            end
          end else if (half_wrap) begin
            cnt      <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + EW'(1);
            // CPHA=0 samples on odd edges, CPHA=1 on even edges; the other edge shifts
            if (odd_edge ^ cpha_q) begin
              rx_sh <= {rx_sh[D_WIDTH-2:0], sample_bit};
            end else begin
              mosi  <= tx_sh[D_WIDTH-1];
              tx_sh <= {tx_sh[D_WIDTH-2:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          sclk <= cpol_q;
        end
        default: begin
          sclk <= cpol;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed testbench for spi_master_shifter: modes 0/3, continuous words, slave decode, async reset.
// Runs the loopback scenario only when SPI_LOOPBACK_EN is defined.
`timescale 1ns/1ps
module tb_spi_master_shifter;

  localparam int DW = 8;
  localparam int NS = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          cont = 1'b0;
  logic [7:0]    clk_div = 8'd0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] tx_data = '0;
  logic          miso;
  logic          sclk;
  logic          mosi;
  logic [NS-1:0] ss_n;
  logic          busy;
  logic [DW-1:0] rx_data;
  logic          done;
`ifdef SPI_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  logic          lb_ext = 1'b0;
  logic          slave_bit = 1'b0;
  logic [7:0]    slave_word = 8'h00;

  int errors = 0;
  int checks = 0;

  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          busy_cycles, rises, falls, edges, done_count;
  int          fall_cyc [2];
  int          done_cyc [4];
  logic [7:0]  rx_hist [4];
  logic [7:0]  mosi_cap;
  logic [NS-1:0] exp_ss;
  bit          ss_bad;
  logic        prev_sclk = 1'b0;

  assign miso = lb_ext ? mosi : slave_bit;

  always #5 clk = ~clk;

  spi_master_shifter #(.D_WIDTH(DW), .SLAVES(NS), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .cpol    (cpol),
    .cpha    (cpha),
    .cont    (cont),
    .clk_div (clk_div),
    .addr    (addr),
    .tx_data (tx_data),
    .miso    (miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .sclk    (sclk),
    .mosi    (mosi),
    .ss_n    (ss_n),
    .busy    (busy),
    .rx_data (rx_data),
    .done    (done)
  );

  // Observer on the falling clk edge; also plays a slave that shifts out slave_word on SCLK falls
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (busy) busy_cycles++;
      if (busy && ss_n !== exp_ss) ss_bad = 1'b1;
      if (done) begin
        if (done_count < 4) begin
          done_cyc[done_count] = cyc;
          rx_hist[done_count]  = rx_data;
        end
        done_count++;
      end
      if (sclk !== prev_sclk) edges++;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], mosi};
      end
      if (!sclk && prev_sclk) begin
        if (falls < 2) fall_cyc[falls] = cyc;
        falls++;
        slave_bit  = slave_word[7];
        slave_word = {slave_word[6:0], 1'b0};
      end
    end
    prev_sclk = sclk;
  end

  task automatic clear_mon(input logic [NS-1:0] ss_expect);
    busy_cycles = 0;
    rises       = 0;
    falls       = 0;
    edges       = 0;
    done_count  = 0;
    mosi_cap    = 8'h00;
    ss_bad      = 1'b0;
    exp_ss      = ss_expect;
    mon_en      = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic start_and_wait(input int limit);
    int n;
    n = 0;
    @(negedge clk); #1 enable = 1'b1;
    @(negedge clk); #1 enable = 1'b0;
    while (busy && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout: busy=%b required 0", busy);
    end
    settle();
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks += 6;
    if (sclk !== 1'b0)    begin errors++; $display("[TB] FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0)    begin errors++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
    if (ss_n !== 2'b11)   begin errors++; $display("[TB] FAIL reset_ss_n: got %b want 11", ss_n); end
    if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx: got %h want 00", rx_data); end
    if (done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    reset_n = 1'b1;
    settle();
  endtask

  task automatic test_mode0();
    cpol = 1'b0; cpha = 1'b0; cont = 1'b0; clk_div = 8'd0; addr = 2'd0;
    lb_ext = 1'b1; tx_data = 8'hA5;
    settle();
    clear_mon(2'b10);
    start_and_wait(200);
    checks += 5;
    if (busy_cycles !== 18) begin errors++; $display("[TB] FAIL m0_busy_len: got %0d want 18", busy_cycles); end
    if (rises !== 8)        begin errors++; $display("[TB] FAIL m0_rises: got %0d want 8", rises); end
    if (rx_data !== 8'hA5)  begin errors++; $display("[TB] FAIL m0_rx: got %h want a5", rx_data); end
    if (done_count !== 1)   begin errors++; $display("[TB] FAIL m0_done: got %0d want 1", done_count); end
    if (ss_bad !== 1'b0)    begin errors++; $display("[TB] FAIL m0_ss: got bad=%b want 0", ss_bad); end
  endtask

  task automatic test_mode3();
    cpol = 1'b1; cpha = 1'b1; cont = 1'b0; clk_div = 8'd3; addr = 2'd0;
    lb_ext = 1'b0; tx_data = 8'h96;
    settle();
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("[TB] FAIL m3_idle_pre: got %b want 1", sclk); end
    slave_word = 8'h3C;
    clear_mon(2'b10);
    start_and_wait(400);
    checks += 6;
    if (busy_cycles !== 69)  begin errors++; $display("[TB] FAIL m3_busy_len: got %0d want 69", busy_cycles); end
    if (fall_cyc[1] - fall_cyc[0] !== 8) begin errors++; $display("[TB] FAIL m3_period: got %0d want 8", fall_cyc[1] - fall_cyc[0]); end
    if (rx_data !== 8'h3C)   begin errors++; $display("[TB] FAIL m3_rx: got %h want 3c", rx_data); end
    if (mosi_cap !== 8'h96)  begin errors++; $display("[TB] FAIL m3_mosi: got %h want 96", mosi_cap); end
    if (sclk !== 1'b1)       begin errors++; $display("[TB] FAIL m3_idle_post: got %b want 1", sclk); end
    if (rises !== 8)         begin errors++; $display("[TB] FAIL m3_rises: got %0d want 8", rises); end
    slave_bit = 1'b0;
  endtask

  task automatic test_continuous();
    int n;
    cpol = 1'b0; cpha = 1'b0; cont = 1'b1; clk_div = 8'd0; addr = 2'd0;
    lb_ext = 1'b1; tx_data = 8'h11;
    settle();
    clear_mon(2'b10);
    @(negedge clk); #1 enable = 1'b1;
    repeat (3) @(negedge clk);
    #1 tx_data = 8'h22;
    n = 0;
    while (done_count < 1 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    settle();
    checks += 6;
    if (done_count !== 2)     begin errors++; $display("[TB] FAIL cont_done_cnt: got %0d want 2", done_count); end
    if (done_cyc[1] - done_cyc[0] !== 17) begin errors++; $display("[TB] FAIL cont_spacing: got %0d want 17", done_cyc[1] - done_cyc[0]); end
    if (busy_cycles !== 35)   begin errors++; $display("[TB] FAIL cont_busy_len: got %0d want 35", busy_cycles); end
    if (ss_bad !== 1'b0)      begin errors++; $display("[TB] FAIL cont_ss_held: got bad=%b want 0", ss_bad); end
    if (rx_hist[0] !== 8'h11) begin errors++; $display("[TB] FAIL cont_rx1: got %h want 11", rx_hist[0]); end
    if (rx_hist[1] !== 8'h22) begin errors++; $display("[TB] FAIL cont_rx2: got %h want 22", rx_hist[1]); end
    cont = 1'b0;
  endtask

  task automatic test_slave_select();
    cpol = 1'b0; cpha = 1'b0; cont = 1'b0; clk_div = 8'd1; addr = 2'd1;
    lb_ext = 1'b1; tx_data = 8'h0F;
    settle();
    clear_mon(2'b01);
    start_and_wait(200);
    checks += 3;
    if (ss_bad !== 1'b0)   begin errors++; $display("[TB] FAIL addr1_ss: got bad=%b want 0", ss_bad); end
    if (rises !== 8)       begin errors++; $display("[TB] FAIL addr1_rises: got %0d want 8", rises); end
    if (rx_data !== 8'h0F) begin errors++; $display("[TB] FAIL addr1_rx: got %h want 0f", rx_data); end
    addr = 2'd3; tx_data = 8'hE7;
    settle();
    clear_mon(2'b11);
    start_and_wait(200);
    checks += 3;
    if (ss_bad !== 1'b0)   begin errors++; $display("[TB] FAIL addr3_ss: got bad=%b want 0", ss_bad); end
    if (rises !== 8)       begin errors++; $display("[TB] FAIL addr3_rises: got %0d want 8", rises); end
    if (rx_data !== 8'hE7) begin errors++; $display("[TB] FAIL addr3_rx: got %h want e7", rx_data); end
    addr = 2'd0;
  endtask

  task automatic test_reset_midway();
    int n;
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; addr = 2'd0;
    lb_ext = 1'b1; tx_data = 8'hA5;
    settle();
    clear_mon(2'b10);
    @(negedge clk); #1 enable = 1'b1;
    @(negedge clk); #1 enable = 1'b0;
    n = 0;
    while (edges < 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 6;
    if (sclk !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_mosi: got %b want 0", mosi); end
    if (ss_n !== 2'b11)    begin errors++; $display("[TB] FAIL rst_mid_ss_n: got %b want 11", ss_n); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_rx: got %h want 00", rx_data); end
    if (done !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_done: got %b want 0", done); end
    @(negedge clk); #1 reset_n = 1'b1;
    tx_data = 8'h5A;
    settle();
    clear_mon(2'b10);
    start_and_wait(200);
    checks += 2;
    if (rx_data !== 8'h5A) begin errors++; $display("[TB] FAIL rst_after_rx: got %h want 5a", rx_data); end
    if (done_count !== 1)  begin errors++; $display("[TB] FAIL rst_after_done: got %0d want 1", done_count); end
  endtask

`ifdef SPI_LOOPBACK_EN
  task automatic test_loopback();
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; addr = 2'd0;
    lb_ext = 1'b0; slave_word = 8'h00; slave_bit = 1'b0;
    loopback = 1'b1; tx_data = 8'hC3;
    settle();
    clear_mon(2'b11);
    start_and_wait(200);
    checks += 2;
    if (rx_data !== 8'hC3) begin errors++; $display("[TB] FAIL lb_rx: got %h want c3", rx_data); end
    if (ss_bad !== 1'b0)   begin errors++; $display("[TB] FAIL lb_ss: got bad=%b want 0", ss_bad); end
    loopback = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_continuous();
    test_slave_select();
    test_reset_midway();
`ifdef SPI_LOOPBACK_EN
    test_loopback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
